// File: rtl/alu_sequencer.sv
// Command-side initiator for the 8-bit accumulator ALU: turns command handshakes into ALU selector/operand drive.
// Latency: response valid in the third cycle after the command handshake edge; one command per 4 cycles.
// Backpressure: cmd_ready is low from acceptance until the response is taken; the response is held until rsp_ready.
module alu_sequencer #(
  parameter int W    = 8,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic            cmd_chain,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  output logic [2:0]      alu_in_selector,
  output logic [W-1:0]    alu_num1,
  output logic [W-1:0]    alu_num2,
  output logic [6:0]      alu_out_selector,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_overflow,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_overflow,
  output logic            busy,
  output logic            err_sticky,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    acc_q;
  logic            cmd_ready_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [W-1:0]    rsp_data_q;
  logic            rsp_ovf_q;
  logic            err_sticky_q;
  logic [ERRW-1:0] err_count_q;

  logic            rsp_ovf_d;
  logic [ERRW-1:0] err_count_d;

  // Overflow only counts for MULT; the error counter saturates instead of wrapping.
  always_comb begin
    rsp_ovf_d   = alu_overflow & (op_q == OP_MULT);
    err_count_d = err_count_q;
    if (!(&err_count_q)) begin
      err_count_d = err_count_q + {{(ERRW-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer FSM with all handshake and status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            a_q         <= cmd_chain ? acc_q : cmd_a;
            b_q         <= cmd_b;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ALU operand registers load on this closing edge.
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (op_q == OP_CLR) begin
            rsp_data_q   <= '0;
            rsp_ovf_q    <= 1'b0;
            acc_q        <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
          end else begin
            rsp_data_q <= alu_result;
            rsp_ovf_q  <= rsp_ovf_d;
            acc_q      <= alu_result;
            if (rsp_ovf_d) begin
              err_sticky_q <= 1'b1;
              err_count_q  <= err_count_d;
            end
          end
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // ALU drive follows the latched command in every state; CLR's op code shifts the one-hot out to zero.
  assign alu_num1         = a_q;
  assign alu_num2         = b_q;
  assign alu_in_selector  = (op_q == OP_CLR) ? 3'b001 : 3'b010;
  assign alu_out_selector = 7'b1000000 >> op_q;

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_overflow = rsp_ovf_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed steps plus random commands checked against an arithmetic reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] alu_in_selector;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_selector;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid, rsp_ready, rsp_overflow, busy, err_sticky;
  logic [7:0] rsp_data, err_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] acc_m = 8'h00;
  int         err_m = 0;
  logic       sticky_m = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(8), .ERRW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_in_selector(alu_in_selector), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_selector(alu_out_selector), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .busy(busy), .err_sticky(err_sticky), .err_count(err_count)
  );

  // ALU model: operand registers, combinational result selected by the one-hot output selector
  logic [7:0] n1 = 8'h00, n2 = 8'h00;
  logic [15:0] prod;
  always @(posedge clk) begin
    if (alu_in_selector == 3'b001) begin
      n1 <= 8'h00; n2 <= 8'h00;
    end else if (alu_in_selector == 3'b010) begin
      n1 <= alu_num1; n2 <= alu_num2;
    end
  end
  always_comb begin
    prod = 16'(n1) * 16'(n2);
    alu_overflow = (prod > 16'd255);
    case (alu_out_selector)
      7'b1000000: alu_result = n1 & n2;
      7'b0100000: alu_result = n1 | n2;
      7'b0010000: alu_result = ~n1;
      7'b0001000: alu_result = n1 ^ n2;
      7'b0000100: alu_result = n1 + n2;
      7'b0000010: alu_result = n1 - n2;
      7'b0000001: alu_result = prod[7:0];
      default:    alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it through ISSUE, CAPTURE and RESPOND; hold = cycles of rsp_ready low.
  task automatic do_cmd(input logic [2:0] op, input logic ch, input logic [7:0] a,
                        input logic [7:0] b, input int hold);
    logic [7:0] a_eff, exp_d;
    logic       exp_o;
    int         prodi, n;
    a_eff = ch ? acc_m : a;
    prodi = int'(a_eff) * int'(b);
    exp_o = 1'b0;
    case (op)
      3'd0: exp_d = a_eff & b;
      3'd1: exp_d = a_eff | b;
      3'd2: exp_d = ~a_eff;
      3'd3: exp_d = a_eff ^ b;
      3'd4: exp_d = a_eff + b;
      3'd5: exp_d = a_eff - b;
      3'd6: begin exp_d = prodi[7:0]; exp_o = (prodi > 255); end
      default: exp_d = 8'h00;
    endcase
    if (op == 3'd7) begin
      acc_m = 8'h00; err_m = 0; sticky_m = 1'b0;
    end else begin
      acc_m = exp_d;
      if (exp_o) begin
        sticky_m = 1'b1;
        if (err_m < 255) err_m++;
      end
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_chain = ch; cmd_a = a; cmd_b = b;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    // ISSUE
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("issue_num1", 32'(alu_num1), 32'(a_eff));
    chk("issue_num2", 32'(alu_num2), 32'(b));
    chk("issue_out_sel", 32'(alu_out_selector), (op == 3'd7) ? 32'd0 : 32'(7'b1000000 >> op));
    chk("issue_in_sel", 32'(alu_in_selector), (op == 3'd7) ? 32'd1 : 32'd2);
    chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    // CAPTURE
    chk("capture_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    // RESPOND
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_overflow", 32'(rsp_overflow), 32'(exp_o));
    chk("err_sticky", 32'(err_sticky), 32'(sticky_m));
    chk("err_count", 32'(err_count), 32'(err_m));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_chain = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_num1", 32'(alu_num1), 32'(a_eff));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_chain = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00; rsp_ready = 1'b1;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_sel", 32'(alu_in_selector), 32'd2);
    chk("rst_out_sel", 32'(alu_out_selector), 32'h40);
    chk("rst_num1", 32'(alu_num1), 32'd0);
    chk("rst_num2", 32'(alu_num2), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk); rst = 1'b1;

    // chain from reset uses a zero accumulator
    do_cmd(3'd4, 1'b1, 8'hAA, 8'h07, 0);
    // basic ADD
    do_cmd(3'd4, 1'b0, 8'h3C, 8'h05, 0);
    // MULT overflow, then CLR wipes the error state
    do_cmd(3'd6, 1'b0, 8'h20, 8'h10, 0);
    do_cmd(3'd7, 1'b0, 8'h55, 8'h66, 0);
    // chained sequence
    do_cmd(3'd4, 1'b0, 8'h05, 8'h03, 0);
    do_cmd(3'd5, 1'b1, 8'hEE, 8'h02, 0);
    do_cmd(3'd0, 1'b1, 8'hEE, 8'h04, 0);
    // backpressure with a competing command offered during RESPOND
    do_cmd(3'd3, 1'b0, 8'hF0, 8'h3C, 5);
    do_cmd(3'd2, 1'b0, 8'h0F, 8'h00, 0);

    // reset during CAPTURE of an ADD
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_chain = 1'b0; cmd_a = 8'h11; cmd_b = 8'h22; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_in_sel", 32'(alu_in_selector), 32'd2);
    chk("midrst_out_sel", 32'(alu_out_selector), 32'h40);
    chk("midrst_num1", 32'(alu_num1), 32'd0);
    acc_m = 8'h00; err_m = 0; sticky_m = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_cmd(3'd4, 1'b0, 8'h11, 8'h22, 0);

    // random commands
    for (int i = 0; i < 40; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)));
    end

    // saturation of the overflow counter
    do_cmd(3'd7, 1'b0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 260; i++) begin
      do_cmd(3'd6, 1'b0, 8'h20, 8'h10, 0);
    end
    chk("sat_err_count", 32'(err_count), 32'hFF);
    chk("sat_err_sticky", 32'(err_sticky), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
